// File: rtl/eth_pkg.sv
// Shared Ethernet RX definitions: header geometry, broadcast address, write-side states
// and small helpers used by the payload FIFO.
package eth_pkg;

  localparam int          ETH_HDR_LEN     = 14;
  localparam logic [47:0] ETH_BCAST       = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_MIN_PAYLOAD = 46;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } rx_state_e;

  // Byte idx (0 = first on the wire) of a big-endian MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    return 8'(mac >> (6'd40 - {idx, 3'b000}));
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/bram_dp.sv
// Simple dual-port byte RAM: one write port, one registered read port with enable,
// so the read data holds between reads.
module bram_dp #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Read data register, only updated on a read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/eth_rx_payload_fifo.sv
// RX stage: filters frames on destination MAC and EtherType, strips the header and
// stores the payload in a frame-atomic FIFO that only exposes cleanly ended frames.
module eth_rx_payload_fifo
  import eth_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 11,
  parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_mac_data,
  input  logic        i_mac_valid,
  input  logic        i_mac_sof,
  input  logic        i_mac_eof,
  input  logic        i_mac_err,
  output logic [7:0]  o_rdata,
  output logic        o_rready,
  input  logic        i_rreq,
  output logic        o_frame_ok,
  output logic [15:0] o_drop_cnt
);

  localparam int            PW       = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] DEPTH    = PTR_ONE << DEPTH_LOG2;
  localparam logic [15:0]   MAX_PAY  = 16'(MAX_PAYLOAD);
  localparam logic [3:0]    HDR_LAST = 4'(ETH_HDR_LEN - 1);

  rx_state_e     state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic          uc_ok_q, uc_ok_d;
  logic          bc_ok_q, bc_ok_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q;
  logic [15:0]   pay_cnt_q, pay_cnt_d;
  logic [15:0]   drop_cnt_q;
  logic          frame_ok_q;

  logic          we_s;
  logic          commit_s;
  logic [1:0]    drop_inc_s;
  logic          hdr_s;
  logic [3:0]    hdr_idx_s;
  logic          uc_s;
  logic          bc_s;
  logic          type_ok_s;
  logic          miss_s;
  logic          full_s;
  logic          pop_s;

  // Full is judged on the pre-pop occupancy, including uncommitted bytes.
  assign full_s    = ((wr_ptr_q - rd_ptr_q) == DEPTH);
  assign o_rready  = (wr_commit_q != rd_ptr_q);
  assign pop_s     = i_rreq & o_rready;
  assign hdr_idx_s = i_mac_sof ? 4'd0 : idx_q;

  // Header field match for the byte at hdr_idx_s; MAC must be all-local or all-broadcast.
  always_comb begin
    uc_s      = (hdr_idx_s == 4'd0) ? 1'b1 : uc_ok_q;
    bc_s      = (hdr_idx_s == 4'd0) ? 1'b1 : bc_ok_q;
    type_ok_s = 1'b1;
    if (hdr_idx_s < 4'd6) begin
      uc_s = uc_s & (i_mac_data == mac_byte(LOCAL_MAC, hdr_idx_s[2:0]));
      bc_s = bc_s & (i_mac_data == ETH_BCAST[7:0]);
    end else if (hdr_idx_s == 4'd12) begin
      type_ok_s = (i_mac_data == ETHERTYPE[15:8]);
    end else if (hdr_idx_s == HDR_LAST) begin
      type_ok_s = (i_mac_data == ETHERTYPE[7:0]);
    end else begin
      type_ok_s = 1'b1;
    end
    miss_s = ~(uc_s | bc_s) | ~type_ok_s;
  end

  // Write-side next state: header filter, payload write, commit and rollback.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    uc_ok_d     = uc_ok_q;
    bc_ok_d     = bc_ok_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    pay_cnt_d   = pay_cnt_q;
    we_s        = 1'b0;
    commit_s    = 1'b0;
    drop_inc_s  = 2'd0;
    hdr_s       = 1'b0;
    if (i_mac_valid) begin
      if (i_mac_sof) begin
        // A new frame always wins; an unfinished one is rolled back and counted.
        hdr_s    = 1'b1;
        wr_ptr_d = wr_commit_q;
        if (state_q != IDLE) begin
          drop_inc_s = 2'd1;
        end else begin
          drop_inc_s = 2'd0;
        end
      end else begin
        case (state_q)
          HDR: begin
            hdr_s = 1'b1;
          end
          PAYLOAD: begin
            if (full_s || (pay_cnt_q == MAX_PAY)) begin
              wr_ptr_d   = wr_commit_q;
              drop_inc_s = 2'd1;
              state_d    = i_mac_eof ? IDLE : DROP;
            end else if (i_mac_eof && i_mac_err) begin
              wr_ptr_d   = wr_commit_q;
              drop_inc_s = 2'd1;
              state_d    = IDLE;
            end else begin
              we_s      = 1'b1;
              wr_ptr_d  = wr_ptr_q + PTR_ONE;
              pay_cnt_d = pay_cnt_q + 16'd1;
              if (i_mac_eof) begin
                wr_commit_d = wr_ptr_q + PTR_ONE;
                commit_s    = 1'b1;
                state_d     = IDLE;
              end else begin
                state_d = PAYLOAD;
              end
            end
          end
          DROP: begin
            state_d = i_mac_eof ? IDLE : DROP;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
      if (hdr_s) begin
        uc_ok_d = uc_s;
        bc_ok_d = bc_s;
        if (i_mac_eof) begin
          state_d = IDLE;
          // A complete but filtered header stays silent; runts and errored frames count.
          if (hdr_idx_s != HDR_LAST) begin
            drop_inc_s = drop_inc_s + 2'd1;
          end else if (!miss_s && !i_mac_err) begin
            commit_s = 1'b1;
          end else if (!miss_s) begin
            drop_inc_s = drop_inc_s + 2'd1;
          end else begin
            drop_inc_s = drop_inc_s;
          end
        end else if (miss_s) begin
          state_d = DROP;
        end else if (hdr_idx_s == HDR_LAST) begin
          state_d   = PAYLOAD;
          pay_cnt_d = 16'd0;
        end else begin
          state_d = HDR;
          idx_d   = hdr_idx_s + 4'd1;
        end
      end else begin
        hdr_s = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Write-side state and pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      uc_ok_q     <= 1'b0;
      bc_ok_q     <= 1'b0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      pay_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      uc_ok_q     <= uc_ok_d;
      bc_ok_q     <= bc_ok_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      pay_cnt_q   <= pay_cnt_d;
    end
  end

  // Read pointer advances only on an accepted pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
    end else if (pop_s) begin
      rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Status outputs: commit pulse and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_ok_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      frame_ok_q <= commit_s;
      drop_cnt_q <= sat_add16(drop_cnt_q, drop_inc_s);
    end
  end

  assign o_frame_ok = frame_ok_q;
  assign o_drop_cnt = drop_cnt_q;

  bram_dp #(
    .AW (DEPTH_LOG2),
    .DW (8)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (we_s),
    .i_waddr (wr_ptr_q[DEPTH_LOG2-1:0]),
    .i_wdata (i_mac_data),
    .i_re    (pop_s),
    .i_raddr (rd_ptr_q[DEPTH_LOG2-1:0]),
    .o_rdata (o_rdata)
  );

endmodule

// File: tb/tb_eth_rx_payload_fifo.sv
// Directed bench for eth_rx_payload_fifo with a 64-byte FIFO: filtering, commit,
// rollback, overflow, sof abort, empty-read handling and asynchronous reset.
module tb_eth_rx_payload_fifo;

  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BMAC = 48'hFFFF_FFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [7:0]  i_mac_data = 8'd0;
  logic        i_mac_valid = 1'b0;
  logic        i_mac_sof = 1'b0;
  logic        i_mac_eof = 1'b0;
  logic        i_mac_err = 1'b0;
  logic        i_rreq = 1'b0;
  logic [7:0]  o_rdata;
  logic        o_rready;
  logic        o_frame_ok;
  logic [15:0] o_drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  eth_rx_payload_fifo #(
    .DEPTH_LOG2 (6)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_mac_data  (i_mac_data),
    .i_mac_valid (i_mac_valid),
    .i_mac_sof   (i_mac_sof),
    .i_mac_eof   (i_mac_eof),
    .i_mac_err   (i_mac_err),
    .o_rdata     (o_rdata),
    .o_rready    (o_rready),
    .i_rreq      (i_rreq),
    .o_frame_ok  (o_frame_ok),
    .o_drop_cnt  (o_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mac_put(input logic [7:0] d, input logic s, input logic e, input logic r);
    @(negedge i_clk);
    i_mac_data  = d;
    i_mac_valid = 1'b1;
    i_mac_sof   = s;
    i_mac_eof   = e;
    i_mac_err   = r;
    @(posedge i_clk);
  endtask

  // Header (dst, fixed src, type) then len payload bytes base, base+1, ...
  task automatic send_frame(input logic [47:0] dst, input logic [15:0] ety, input int len,
                            input logic [7:0] base, input logic err, input logic eof);
    logic [7:0] b;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) b = dst[47-8*i -: 8];
      else if (i < 12) b = 8'(8'h10 + i);
      else if (i == 12) b = ety[15:8];
      else b = ety[7:0];
      mac_put(b, i == 0, eof && (len == 0) && (i == 13), err && (len == 0) && (i == 13));
    end
    for (int i = 0; i < len; i++) begin
      mac_put(8'(base + i), 1'b0, eof && (i == len - 1), err && (i == len - 1));
    end
    @(negedge i_clk);
    i_mac_valid = 1'b0;
    i_mac_sof   = 1'b0;
    i_mac_eof   = 1'b0;
    i_mac_err   = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_rdy"}, 32'(o_rready), 32'd1);
    i_rreq = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rreq = 1'b0;
    check(tag, 32'(o_rdata), 32'(exp));
  endtask

  initial begin
    // Reset values
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_rdata", 32'(o_rdata), 32'd0);
    check("rst_rready", 32'(o_rready), 32'd0);
    check("rst_frame_ok", 32'(o_frame_ok), 32'd0);
    check("rst_drop", 32'(o_drop_cnt), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Good 46-byte frame to the local MAC
    send_frame(LMAC, 16'h88B5, 46, 8'h00, 1'b0, 1'b1);
    check("A_frame_ok", 32'(o_frame_ok), 32'd1);
    @(negedge i_clk);
    check("A_frame_ok_1cyc", 32'(o_frame_ok), 32'd0);
    for (int i = 0; i < 46; i++) pop_check("A_data", 8'(i));
    check("A_empty", 32'(o_rready), 32'd0);
    check("A_drop", 32'(o_drop_cnt), 32'd0);

    // Broadcast frame ending with MAC error, then a good 3-byte frame
    send_frame(BMAC, 16'h88B5, 2, 8'hAA, 1'b1, 1'b1);
    check("B_frame_ok", 32'(o_frame_ok), 32'd0);
    check("B_rready", 32'(o_rready), 32'd0);
    check("B_drop", 32'(o_drop_cnt), 32'd1);
    send_frame(LMAC, 16'h88B5, 3, 8'h01, 1'b0, 1'b1);
    check("C_frame_ok", 32'(o_frame_ok), 32'd1);
    for (int i = 0; i < 3; i++) pop_check("C_data", 8'(8'h01 + i));
    check("C_empty", 32'(o_rready), 32'd0);

    // Wrong EtherType: silent filter miss
    send_frame(LMAC, 16'h0800, 4, 8'h50, 1'b0, 1'b1);
    check("D_frame_ok", 32'(o_frame_ok), 32'd0);
    check("D_rready", 32'(o_rready), 32'd0);
    check("D_drop", 32'(o_drop_cnt), 32'd1);

    // Overflow: 70 bytes into 64, then exactly 64 bytes
    send_frame(LMAC, 16'h88B5, 70, 8'h00, 1'b0, 1'b1);
    check("E_frame_ok", 32'(o_frame_ok), 32'd0);
    check("E_rready", 32'(o_rready), 32'd0);
    check("E_drop", 32'(o_drop_cnt), 32'd2);
    send_frame(LMAC, 16'h88B5, 64, 8'h40, 1'b0, 1'b1);
    check("F_frame_ok", 32'(o_frame_ok), 32'd1);
    for (int i = 0; i < 64; i++) pop_check("F_data", 8'(8'h40 + i));
    check("F_empty", 32'(o_rready), 32'd0);

    // sof after 10 payload bytes aborts the first frame
    send_frame(LMAC, 16'h88B5, 10, 8'h70, 1'b0, 1'b0);
    send_frame(LMAC, 16'h88B5, 5, 8'h90, 1'b0, 1'b1);
    check("G_frame_ok", 32'(o_frame_ok), 32'd1);
    check("G_drop", 32'(o_drop_cnt), 32'd3);
    for (int i = 0; i < 5; i++) pop_check("G_data", 8'(8'h90 + i));
    check("G_empty", 32'(o_rready), 32'd0);

    // Zero-byte payload commits with a pulse and no data
    send_frame(LMAC, 16'h88B5, 0, 8'h00, 1'b0, 1'b1);
    check("H_frame_ok", 32'(o_frame_ok), 32'd1);
    check("H_rready", 32'(o_rready), 32'd0);
    @(negedge i_clk);
    check("H_frame_ok_1cyc", 32'(o_frame_ok), 32'd0);

    // i_rreq held high across an empty FIFO while a frame arrives
    i_rreq = 1'b1;
    send_frame(LMAC, 16'h88B5, 4, 8'hC0, 1'b0, 1'b1);
    check("I_rready", 32'(o_rready), 32'd1);
    check("I_hold", 32'(o_rdata), 32'h94);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check("I_data", 32'(o_rdata), 32'(8'hC0 + i));
    end
    check("I_empty", 32'(o_rready), 32'd0);
    @(negedge i_clk);
    check("I_no_dup", 32'(o_rdata), 32'hC3);
    i_rreq = 1'b0;

    // Asynchronous reset mid-stream with committed content present
    send_frame(LMAC, 16'h88B5, 2, 8'hD0, 1'b0, 1'b1);
    send_frame(LMAC, 16'h88B5, 5, 8'hE0, 1'b0, 1'b0);
    check("J_pre_rready", 32'(o_rready), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("J_rdata", 32'(o_rdata), 32'd0);
    check("J_rready", 32'(o_rready), 32'd0);
    check("J_frame_ok", 32'(o_frame_ok), 32'd0);
    check("J_drop", 32'(o_drop_cnt), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("J_post_rready", 32'(o_rready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
